relu_grad_gather: RTL and testbench

- Gathers a scalar stream of 32-bit float gradient words, one per beat, into WIDTH-wide vectors tagged with an 8-bit id.
- Sits directly upstream of relu_backward_layer and drives its in_vec and id inputs.
- Double-buffered: a fill buffer collects the next vector while the output register holds the current one.
- Supports downstream backpressure and a flush that zero-pads a partial vector.

---
 rtl/relu_grad_gather.sv | 103 ++++++++++
 tb/tb_relu_grad_gather.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/relu_grad_gather.sv
// relu_grad_gather: packs a scalar gradient stream into WIDTH-lane vectors.
// A fill buffer collects the next vector while the output register holds the current one.
module relu_grad_gather #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic [7:0]            in_id,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WIDTH-1:0]   out_vec,
    output logic [7:0]            id_out,
    output logic                  id_err,
    output logic [15:0]           vec_count
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]              r_count;
    logic                       r_fill_full;
    logic                       r_in_ready;
    logic [WIDTH-1:0][31:0]     r_fill;
    logic [WIDTH-1:0][31:0]     r_out;
    logic [7:0]                 r_fill_id;
    logic [7:0]                 r_id_out;
    logic                       r_out_valid;
    logic                       r_id_err;
    logic [15:0]                r_vec_count;

    logic w_acc;
    logic w_last;
    logic w_flush;
    logic w_close;
    logic w_xfer;
    logic w_full_nxt;

    assign w_acc   = in_valid && r_in_ready;
    assign w_last  = w_acc && (r_count == CW'(WIDTH - 1));
    // A flush closes the vector only if it holds at least one word
    assign w_flush = flush && !r_fill_full && !w_last &&
                     (w_acc || (r_count != '0));
    assign w_close = w_last || w_flush;
    assign w_xfer  = r_fill_full && (!r_out_valid || out_ready);

    // Closing needs !fill_full, so it can never coincide with a transfer
    assign w_full_nxt = w_close ? 1'b1 : (w_xfer ? 1'b0 : r_fill_full);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_fill_full <= 1'b0;
            r_in_ready  <= 1'b0;
            r_fill      <= '0;
            r_fill_id   <= '0;
            r_id_err    <= 1'b0;
        end else begin
            r_fill_full <= w_full_nxt;
            r_in_ready  <= !w_full_nxt;
            if (w_close)
                r_count <= '0;
            else if (w_acc)
                r_count <= r_count + CW'(1);
            if (w_acc && (r_count == '0))
                r_fill_id <= in_id;
            if (w_acc && (r_count != '0) && (in_id != r_fill_id))
                r_id_err <= 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                if (w_acc && (CW'(i) == r_count))
                    r_fill[i] <= in_data;
                else if (w_flush && (CW'(i) >= r_count))
                    r_fill[i] <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out       <= '0;
            r_id_out    <= '0;
            r_out_valid <= 1'b0;
            r_vec_count <= '0;
        end else if (w_xfer) begin
            r_out       <= r_fill;
            r_id_out    <= r_fill_id;
            r_out_valid <= 1'b1;
            r_vec_count <= r_vec_count + 16'd1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_vec   = r_out;
    assign id_out    = r_id_out;
    assign id_err    = r_id_err;
    assign vec_count = r_vec_count;

endmodule

// File: tb/tb_relu_grad_gather.sv
// tb_relu_grad_gather: directed vectors against hand-computed results.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_relu_grad_gather;

    localparam int W = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    logic [7:0]      in_id;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [32*W-1:0] out_vec;
    logic [7:0]      id_out;
    logic            id_err;
    logic [15:0]     vec_count;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int pulse_cyc[$];
    logic [7:0] pulse_id[$];

    relu_grad_gather #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_id(in_id), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .id_out(id_out),
        .id_err(id_err), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid) begin
            pulse_cyc.push_back(cyc);
            pulse_id.push_back(id_out);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return out_vec[32*i +: 32];
    endfunction

    task automatic send(input logic [31:0] d, input logic [7:0] id);
        in_valid = 1'b1;
        in_data  = d;
        in_id    = id;
        for (int t = 0; t < 64 && !in_ready; t++) step();
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_id = '0;
        flush = 1'b0; out_ready = 1'b1;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_cnt", 32'(vec_count), 32'd0);
        chk("rst_lane0", lane(0), 32'd0);
        step(); step();
        reset = 1'b0;
        chk("rdy_before_edge", 32'(in_ready), 32'd0);
        step();
        chk("rdy_after_edge", 32'(in_ready), 32'd1);

        // Basic vector
        for (int i = 0; i < W; i++) send(32'h3F80_0000 + 32'(i), 8'h05);
        chk("t1_ready_low", 32'(in_ready), 32'd0);
        chk("t1_valid_early", 32'(out_valid), 32'd0);
        step();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_ready_back", 32'(in_ready), 32'd1);
        for (int i = 0; i < W; i++)
            chk($sformatf("t1_lane%0d", i), lane(i), 32'h3F80_0000 + 32'(i));
        chk("t1_id", 32'(id_out), 32'h05);
        chk("t1_cnt", 32'(vec_count), 32'd1);
        step();
        chk("t1_pulse_end", 32'(out_valid), 32'd0);

        // Three back-to-back vectors
        pulse_cyc.delete();
        pulse_id.delete();
        for (int v = 1; v <= 3; v++)
            for (int i = 0; i < W; i++)
                send(32'(v * 256 + i), 8'(v));
        step(); step();
        chk("t2_pulses", 32'(pulse_cyc.size()), 32'd3);
        if (pulse_cyc.size() == 3) begin
            chk("t2_gap1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd17);
            chk("t2_gap2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd17);
            chk("t2_id1", 32'(pulse_id[0]), 32'd1);
            chk("t2_id2", 32'(pulse_id[1]), 32'd2);
            chk("t2_id3", 32'(pulse_id[2]), 32'd3);
        end
        chk("t2_cnt", 32'(vec_count), 32'd4);
        chk("t2_iderr", 32'(id_err), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        for (int i = 0; i < W; i++) send(32'h100 + 32'(i), 8'h0A);
        for (int i = 0; i < W; i++) send(32'h200 + 32'(i), 8'h0B);
        step(); step(); step();
        chk("t3_ready_low", 32'(in_ready), 32'd0);
        chk("t3_valid_hold", 32'(out_valid), 32'd1);
        chk("t3_hold_lane0", lane(0), 32'h100);
        chk("t3_hold_lane15", lane(15), 32'h10F);
        chk("t3_hold_id", 32'(id_out), 32'h0A);
        out_ready = 1'b1;
        step();
        chk("t3_new_lane0", lane(0), 32'h200);
        chk("t3_new_lane15", lane(15), 32'h20F);
        chk("t3_new_id", 32'(id_out), 32'h0B);
        chk("t3_new_valid", 32'(out_valid), 32'd1);
        chk("t3_ready_back", 32'(in_ready), 32'd1);
        step();
        chk("t3_consumed", 32'(out_valid), 32'd0);
        chk("t3_cnt", 32'(vec_count), 32'd6);

        // Flush of a partial vector, then a flush with nothing buffered
        for (int i = 0; i < 5; i++) send(32'h4000_0000 + 32'(i), 8'h11);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_valid_early", 32'(out_valid), 32'd0);
        step();
        chk("t4_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < W; i++)
            chk($sformatf("t4_lane%0d", i), lane(i),
                (i < 5) ? 32'h4000_0000 + 32'(i) : 32'd0);
        chk("t4_id", 32'(id_out), 32'h11);
        chk("t4_cnt", 32'(vec_count), 32'd7);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        step(); step();
        chk("t4_empty_valid", 32'(out_valid), 32'd0);
        chk("t4_empty_cnt", 32'(vec_count), 32'd7);
        chk("t4_empty_ready", 32'(in_ready), 32'd1);

        // Id change mid-vector
        for (int i = 0; i < W; i++)
            send(32'h700 + 32'(i), (i < 3) ? 8'h07 : 8'h08);
        step();
        chk("t5_iderr", 32'(id_err), 32'd1);
        chk("t5_id", 32'(id_out), 32'h07);
        chk("t5_cnt", 32'(vec_count), 32'd8);
        step(); step();
        chk("t5_sticky", 32'(id_err), 32'd1);

        // Reset mid-vector
        for (int i = 0; i < 9; i++) send(32'hDEAD_0000 + 32'(i), 8'h22);
        reset = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_ready", 32'(in_ready), 32'd0);
        chk("t6_cnt", 32'(vec_count), 32'd0);
        chk("t6_iderr", 32'(id_err), 32'd0);
        chk("t6_id", 32'(id_out), 32'd0);
        chk("t6_lane0", lane(0), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("t6_ready_back", 32'(in_ready), 32'd1);
        chk("t6_no_output", 32'(out_valid), 32'd0);
        for (int i = 0; i < W; i++) send(32'h5000_0000 + 32'(i), 8'h33);
        step();
        chk("t6_valid_new", 32'(out_valid), 32'd1);
        for (int i = 0; i < W; i++)
            chk($sformatf("t6_lane%0d", i), lane(i), 32'h5000_0000 + 32'(i));
        chk("t6_id_new", 32'(id_out), 32'h33);
        chk("t6_cnt_new", 32'(vec_count), 32'd1);
        chk("t6_iderr_new", 32'(id_err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
